// File: rtl/alu_exec_stage.sv
// ARM-style ALU execute stage: one-deep registered result with valid/ready
// handshake, RRX substitution and an architectural NZCV flag register.
module alu_exec_stage #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    cmd,
  input  logic          s_bit,
  input  logic          rrx,
  input  logic [DW-1:0] src1,
  input  logic [DW-1:0] src2,
  input  logic          sh_c,
  input  logic          sh_c_valid,
  input  logic [3:0]    rd_in,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] result,
  output logic [3:0]    rd_out,
  output logic          wr_en,
  output logic [3:0]    flags
);

  typedef enum logic [3:0] {
    OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
    OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
    OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
    OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF
  } op_e;

  op_e           op;
  logic          accept;
  logic          is_test;
  logic          is_arith;
  logic          update_flags;
  logic          flag_c;
  logic          flag_v;

  logic [DW-1:0] op2;
  logic          op2_c;
  logic          op2_c_valid;

  logic [DW-1:0] add_a;
  logic [DW-1:0] add_b;
  logic          add_cin;
  logic [DW:0]   sum;

  logic [DW-1:0] alu_res;
  logic [3:0]    flags_nxt;

  assign op       = op_e'(cmd);
  assign flag_c   = flags[1];
  assign flag_v   = flags[0];
  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_test  = (op == OP_TST) || (op == OP_TEQ) || (op == OP_CMP) || (op == OP_CMN);
  assign update_flags = accept && (s_bit || is_test);

  // RRX rotates the current carry into bit 31 and shifts bit 0 out as carry.
  always_comb begin
    op2         = src2;
    op2_c       = sh_c;
    op2_c_valid = sh_c_valid;
    if (rrx) begin
      op2         = {flag_c, src2[DW-1:1]};
      op2_c       = src2[0];
      op2_c_valid = 1'b1;
    end
  end

  // Every arithmetic opcode reduces to a + b + cin on a 33-bit adder.
  always_comb begin
    is_arith = 1'b1;
    add_a    = src1;
    add_b    = op2;
    add_cin  = 1'b0;
    case (op)
      OP_SUB, OP_CMP: begin add_b = ~op2; add_cin = 1'b1; end
      OP_RSB:         begin add_a = op2; add_b = ~src1; add_cin = 1'b1; end
      OP_ADD, OP_CMN: begin add_cin = 1'b0; end
      OP_ADC:         begin add_cin = flag_c; end
      OP_SBC:         begin add_b = ~op2; add_cin = flag_c; end
      OP_RSC:         begin add_a = op2; add_b = ~src1; add_cin = flag_c; end
      default:        is_arith = 1'b0;
    endcase
    sum = {1'b0, add_a} + {1'b0, add_b} + {{DW{1'b0}}, add_cin};
  end

  always_comb begin
    alu_res = sum[DW-1:0];
    case (op)
      OP_AND, OP_TST: alu_res = src1 & op2;
      OP_EOR, OP_TEQ: alu_res = src1 ^ op2;
      OP_ORR:         alu_res = src1 | op2;
      OP_MOV:         alu_res = op2;
      OP_BIC:         alu_res = src1 & ~op2;
      OP_MVN:         alu_res = ~op2;
      default:        alu_res = sum[DW-1:0];
    endcase
  end

  // Logical ops keep V, and keep C unless the shifter produced a carry.
  always_comb begin
    flags_nxt    = flags;
    flags_nxt[3] = alu_res[DW-1];
    flags_nxt[2] = (alu_res == '0);
    if (is_arith) begin
      flags_nxt[1] = sum[DW];
      flags_nxt[0] = (add_a[DW-1] == add_b[DW-1]) && (sum[DW-1] != add_a[DW-1]);
    end else begin
      flags_nxt[1] = op2_c_valid ? op2_c : flag_c;
      flags_nxt[0] = flag_v;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      rd_out    <= 4'd0;
      wr_en     <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      result    <= alu_res;
      rd_out    <= rd_in;
      wr_en     <= !is_test;
    end else if (flush || out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags <= 4'b0000;
    end else if (update_flags) begin
      flags <= flags_nxt;
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: hand-computed results, flags and
// handshake behaviour checked with immediate assertions.
module tb_alu_exec_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  cmd;
  logic        s_bit;
  logic        rrx;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        sh_c;
  logic        sh_c_valid;
  logic [3:0]  rd_in;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  rd_out;
  logic        wr_en;
  logic [3:0]  flags;

  int errors = 0;
  int checks = 0;

  alu_exec_stage #(.DW(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .cmd        (cmd),
    .s_bit      (s_bit),
    .rrx        (rrx),
    .src1       (src1),
    .src2       (src2),
    .sh_c       (sh_c),
    .sh_c_valid (sh_c_valid),
    .rd_in      (rd_in),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .rd_out     (rd_out),
    .wr_en      (wr_en),
    .flags      (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic valid, input logic [3:0] op,
                                input logic s, input logic r,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic c, input logic cv,
                                input logic [3:0] rd);
    in_valid   = valid;
    cmd        = op;
    s_bit      = s;
    rrx        = r;
    src1       = a;
    src2       = b;
    sh_c       = c;
    sh_c_valid = cv;
    rd_in      = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    apply_stimulus(1'b0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0);
    #2;
    check_output("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_output("rst_result",    result,             32'd0);
    check_output("rst_rd_out",    {28'd0, rd_out},    32'd0);
    check_output("rst_wr_en",     {31'd0, wr_en},     32'd0);
    check_output("rst_flags",     {28'd0, flags},     32'd0);

    @(negedge clk);
    rst_n = 1'b1;

    // ADDS overflow into the sign bit
    apply_stimulus(1'b1, 4'h4, 1'b1, 1'b0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 4'd3);
    #1;
    check_output("add_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check_output("add_out_valid", {31'd0, out_valid}, 32'd1);
    check_output("add_result",    result,             32'h80000000);
    check_output("add_flags",     {28'd0, flags},     32'h9);
    check_output("add_wr_en",     {31'd0, wr_en},     32'd1);
    check_output("add_rd_out",    {28'd0, rd_out},    32'd3);

    apply_stimulus(1'b1, 4'hA, 1'b0, 1'b0, 32'd5, 32'd5, 1'b0, 1'b0, 4'd4);
    tick();
    check_output("cmp_flags", {28'd0, flags}, 32'h6);
    check_output("cmp_wr_en", {31'd0, wr_en}, 32'd0);

    apply_stimulus(1'b1, 4'h5, 1'b0, 1'b0, 32'd1, 32'd1, 1'b0, 1'b0, 4'd5);
    tick();
    check_output("adc_result", result,         32'd3);
    check_output("adc_flags",  {28'd0, flags}, 32'h6);
    check_output("adc_wr_en",  {31'd0, wr_en}, 32'd1);

    apply_stimulus(1'b1, 4'hD, 1'b1, 1'b1, 32'h0, 32'h00000003, 1'b0, 1'b0, 4'd6);
    tick();
    check_output("rrx_result", result,         32'h80000001);
    check_output("rrx_flags",  {28'd0, flags}, 32'hA);

    // Downstream stalls for two cycles with a new ADDS waiting
    out_ready = 1'b0;
    apply_stimulus(1'b1, 4'h4, 1'b1, 1'b0, 32'd1, 32'd1, 1'b0, 1'b0, 4'd7);
    #1;
    check_output("stall_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    check_output("stall1_result", result,             32'h80000001);
    check_output("stall1_valid",  {31'd0, out_valid}, 32'd1);
    check_output("stall1_flags",  {28'd0, flags},     32'hA);
    tick();
    check_output("stall2_result", result,             32'h80000001);
    check_output("stall2_flags",  {28'd0, flags},     32'hA);
    check_output("stall2_rd_out", {28'd0, rd_out},    32'd6);
    out_ready = 1'b1;
    #1;
    check_output("drain_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check_output("drain_result", result,             32'd2);
    check_output("drain_valid",  {31'd0, out_valid}, 32'd1);
    check_output("drain_flags",  {28'd0, flags},     32'h0);

    apply_stimulus(1'b0, 4'h4, 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 4'd8);
    tick();
    check_output("idle_valid", {31'd0, out_valid}, 32'd0);
    check_output("idle_flags", {28'd0, flags},     32'h0);

    apply_stimulus(1'b1, 4'h2, 1'b1, 1'b0, 32'd3, 32'd5, 1'b0, 1'b0, 4'd7);
    tick();
    check_output("sub_neg_result", result,         32'hFFFFFFFE);
    check_output("sub_neg_flags",  {28'd0, flags}, 32'h8);

    apply_stimulus(1'b1, 4'h2, 1'b1, 1'b0, 32'h80000000, 32'd1, 1'b0, 1'b0, 4'd7);
    tick();
    check_output("sub_ovf_result", result,         32'h7FFFFFFF);
    check_output("sub_ovf_flags",  {28'd0, flags}, 32'h3);

    apply_stimulus(1'b1, 4'h0, 1'b1, 1'b0, 32'hF0F0F0F0, 32'h0F0F0F0F, 1'b1, 1'b1, 4'd1);
    tick();
    check_output("and_result", result,         32'h0);
    check_output("and_flags",  {28'd0, flags}, 32'h7);

    apply_stimulus(1'b1, 4'h1, 1'b1, 1'b0, 32'hFFFF0000, 32'h0000FFFF, 1'b0, 1'b0, 4'd2);
    tick();
    check_output("eor_result", result,         32'hFFFFFFFF);
    check_output("eor_flags",  {28'd0, flags}, 32'hB);

    // Flush with a valid op upstream and a valid result held
    flush = 1'b1;
    apply_stimulus(1'b1, 4'h4, 1'b1, 1'b0, 32'h1, 32'h1, 1'b0, 1'b0, 4'd9);
    #1;
    check_output("flush_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    check_output("flush_valid",  {31'd0, out_valid}, 32'd0);
    check_output("flush_flags",  {28'd0, flags},     32'hB);
    check_output("flush_result", result,             32'hFFFFFFFF);
    check_output("flush_rd_out", {28'd0, rd_out},    32'd2);
    flush = 1'b0;

    apply_stimulus(1'b1, 4'h3, 1'b1, 1'b0, 32'd1, 32'd10, 1'b0, 1'b0, 4'd10);
    tick();
    check_output("rsb_result", result,         32'd9);
    check_output("rsb_flags",  {28'd0, flags}, 32'h2);

    apply_stimulus(1'b1, 4'h6, 1'b1, 1'b0, 32'd10, 32'd3, 1'b0, 1'b0, 4'd11);
    tick();
    check_output("sbc_result", result,         32'd7);
    check_output("sbc_flags",  {28'd0, flags}, 32'h2);

    apply_stimulus(1'b1, 4'h5, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 4'd12);
    tick();
    check_output("adcs_result", result,         32'h0);
    check_output("adcs_flags",  {28'd0, flags}, 32'h6);

    // Reset asserted mid-stall, between clock edges
    out_ready = 1'b0;
    apply_stimulus(1'b0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 4'd0);
    tick();
    check_output("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_output("async_rst_valid",  {31'd0, out_valid}, 32'd0);
    check_output("async_rst_flags",  {28'd0, flags},     32'd0);
    check_output("async_rst_result", result,             32'd0);
    check_output("async_rst_wr_en",  {31'd0, wr_en},     32'd0);

    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    apply_stimulus(1'b1, 4'hF, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 4'd9);
    tick();
    check_output("post_rst_valid",  {31'd0, out_valid}, 32'd1);
    check_output("post_rst_result", result,             32'hFFFFFFFF);
    check_output("post_rst_flags",  {28'd0, flags},     32'h8);
    check_output("post_rst_rd_out", {28'd0, rd_out},    32'd9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
